// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master data-memory arbiter:
// FSM state encoding, default widths and burst-limit helpers.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W    = 32;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_MAX_BURST = 4;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Saturation value for the 4-bit beat counter; a 16-beat limit cannot be
  // held in 4 bits, so the counter parks at 15 in that case.
  function automatic logic [CNT_W-1:0] cnt_limit(input int unsigned max_burst);
    if (max_burst > 15) begin
      return 4'd15;
    end
    return 4'(max_burst);
  endfunction

  // Counter value at which the current beat is beat number max_burst.
  function automatic logic [CNT_W-1:0] force_point(input int unsigned max_burst);
    return 4'(max_burst - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the
// shared data memory. The arbiter uses the slave modport; whatever drives
// the requests and models the memory uses the master modport.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  // master 0: CPU MEM stage
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  // master 1: external device
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              cpu_stall;

  // shared memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output cpu_stall,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  cpu_stall,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_arb_owner_mux.sv
// Combinational master-to-memory steering. Only the master performing a
// beat this cycle reaches the memory; with no beat every memory-side
// output is driven to zero.
module arb_owner_mux
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              beat0,
  input  logic              beat1,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  // Select the beating master's command, or an all-zero idle command.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (beat0) begin
      mem_read  = ~m0_we;
      mem_write = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (beat1) begin
      mem_read  = ~m1_we;
      mem_write = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared data memory (CPU MEM stage = m0,
// external device = m1). Grants come straight from the registered owner
// state, so grant latency from an idle bus is one cycle. An owner keeps
// the bus while it requests, unless it has completed MAX_BURST beats and
// the other master is waiting, in which case ownership swaps with no idle
// cycle. Read data returns registered, with a one-cycle rvalid pulse.
//
// Build option: define ARB_ROUND_ROBIN_EN to resolve simultaneous idle
// requests in favour of the master not granted last; otherwise m0 always
// wins ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX  = cnt_limit(MAX_BURST);
  localparam logic [CNT_W-1:0] FORCE_AT = force_point(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;   // 1: m1 was granted most recently
`endif

  logic              gnt0, gnt1;
  logic              beat0, beat1;
  logic              tie_to_m1;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Grants decode registered state; a beat is a granted, requesting cycle.
  always_comb begin
    gnt0  = (state_q == OWN0);
    gnt1  = (state_q == OWN1);
    beat0 = gnt0 & bus.m0_req;
    beat1 = gnt1 & bus.m1_req;
  end

  // Tie-break choice for simultaneous requests on an idle bus.
  always_comb begin
    tie_to_m1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    tie_to_m1 = ~last_q;
`endif
  end

  // Ownership transitions: idle pick-up, voluntary release, forced release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          state_d = tie_to_m1 ? OWN1 : OWN0;
        end else if (bus.m0_req) begin
          state_d = OWN0;
        end else if (bus.m1_req) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!bus.m0_req) begin
          state_d = bus.m1_req ? OWN1 : IDLE;
        end else if (bus.m1_req && (cnt_q >= FORCE_AT)) begin
          state_d = OWN1;
        end
      end
      OWN1: begin
        if (!bus.m1_req) begin
          state_d = bus.m0_req ? OWN0 : IDLE;
        end else if (bus.m0_req && (cnt_q >= FORCE_AT)) begin
          state_d = OWN0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat counter: clears on any ownership change, saturates otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((beat0 || beat1) && (cnt_q < CNT_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which master entered an OWN state most recently.
  always_comb begin
    last_d = last_q;
    if (state_d == OWN0 && state_q != OWN0) begin
      last_d = 1'b0;
    end else if (state_d == OWN1 && state_q != OWN1) begin
      last_d = 1'b1;
    end
  end
`endif

  // Read return: capture memory data on a read beat, pulse rvalid next cycle.
  always_comb begin
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    if (beat0 && !bus.m0_we) begin
      m0_rdata_d  = bus.mem_rdata;
      m0_rvalid_d = 1'b1;
    end
    if (beat1 && !bus.m1_we) begin
      m1_rdata_d  = bus.mem_rdata;
      m1_rvalid_d = 1'b1;
    end
  end

  // FSM and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  arb_owner_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_owner_mux (
    .beat0     (beat0),
    .beat1     (beat1),
    .m0_we     (bus.m0_we),
    .m0_addr   (bus.m0_addr),
    .m0_wdata  (bus.m0_wdata),
    .m1_we     (bus.m1_we),
    .m1_addr   (bus.m1_addr),
    .m1_wdata  (bus.m1_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.cpu_stall = bus.m0_req & ~gnt0;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random request
// traffic, all checked every cycle against a transaction-level model of
// bus ownership (who owns the bus, how many beats it has had, who was
// granted last) plus explicit checks at the scenario milestones.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MAXB = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0;

  // reference model state
  int          own   = -1;   // -1 idle, else owning master
  int          beats = 0;
  int          last  = 1;
  int          pb    = -1;   // master that beat in the last sampled cycle
  bit          rv_m  [2];
  logic [31:0] rd_m  [2];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a ^ 32'hA5A5_1234) + 32'h77;
  endfunction

  assign bus.m0_req    = req[0];
  assign bus.m0_we     = we[0];
  assign bus.m0_addr   = addr[0];
  assign bus.m0_wdata  = wdata[0];
  assign bus.m1_req    = req[1];
  assign bus.m1_we     = we[1];
  assign bus.m1_addr   = addr[1];
  assign bus.m1_wdata  = wdata[1];
  assign bus.mem_rdata = memfn(bus.mem_addr);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    req[i] = r; we[i] = w; addr[i] = a; wdata[i] = d;
  endtask

  // Check all outputs against the model, then advance the model one cycle.
  task automatic sample();
    int bo, nxt, oth;
    bit er, ewr;
    logic [31:0] ea, ew;
    @(negedge clk);
    bo = -1;
    if (own >= 0) begin
      if (req[own]) bo = own;
    end
    er = 1'b0; ewr = 1'b0; ea = '0; ew = '0;
    if (bo >= 0) begin
      er = !we[bo]; ewr = we[bo]; ea = addr[bo]; ew = wdata[bo];
    end
    chk("m_gnt0",  bus.m0_gnt,    own == 0);
    chk("m_gnt1",  bus.m1_gnt,    own == 1);
    chk("m_stall", bus.cpu_stall, req[0] && own != 0);
    chk("m_read",  bus.mem_read,  er);
    chk("m_write", bus.mem_write, ewr);
    chk("m_addr",  bus.mem_addr,  ea);
    chk("m_wdata", bus.mem_wdata, ew);
    chk("m_rv0",   bus.m0_rvalid, rv_m[0]);
    chk("m_rv1",   bus.m1_rvalid, rv_m[1]);
    chk("m_rd0",   bus.m0_rdata,  rd_m[0]);
    chk("m_rd1",   bus.m1_rdata,  rd_m[1]);
    chk("m_cnt",   dut.cnt_q,     64'(beats));
    stall_cnt += int'(bus.cpu_stall);
    pb = bo;
    if (reset) begin
      own = -1; beats = 0; last = 1;
      rv_m[0] = 0; rv_m[1] = 0; rd_m[0] = '0; rd_m[1] = '0;
      return;
    end
    rv_m[0] = 0; rv_m[1] = 0;
    if (bo >= 0 && !we[bo]) begin
      rv_m[bo] = 1;
      rd_m[bo] = memfn(addr[bo]);
    end
    if (own < 0) begin
      if (req[0] && req[1]) nxt = RR ? 1 - last : 0;
      else if (req[0])      nxt = 0;
      else if (req[1])      nxt = 1;
      else                  nxt = -1;
    end else begin
      oth = 1 - own;
      if (!req[own])                              nxt = req[oth] ? oth : -1;
      else if (beats + 1 >= MAXB && req[oth])     nxt = oth;
      else                                        nxt = own;
    end
    if (nxt != own) begin
      beats = 0;
      if (nxt >= 0) last = nxt;
    end else if (own >= 0) begin
      beats = (beats + 1 > MAXB) ? MAXB : beats + 1;
    end
    own = nxt;
  endtask

  initial begin
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    reset = 1'b1;

    // reset state
    tick();
    sample();
    chk("rst_gnt0",  bus.m0_gnt, 0);
    chk("rst_gnt1",  bus.m1_gnt, 0);
    chk("rst_rv0",   bus.m0_rvalid, 0);
    chk("rst_rd1",   bus.m1_rdata, 0);
    chk("rst_cnt",   dut.cnt_q, 0);
    chk("rst_state", dut.state_q, IDLE);
    tick();
    reset = 1'b0;

    // ties on an idle bus
    set_m(0, 1, 0, 32'h100, '0);
    set_m(1, 1, 0, 32'h200, '0);
    sample(); chk("tie1_wait", bus.m0_gnt, 0); tick();
    sample(); chk("tie1_gnt0", bus.m0_gnt, 1); chk("tie1_gnt1", bus.m1_gnt, 0); tick();
    req[0] = 0; req[1] = 0;
    sample(); tick();
    req[0] = 1; req[1] = 1;
    sample(); tick();
    sample(); chk("tie2_gnt0", bus.m0_gnt, !RR); chk("tie2_gnt1", bus.m1_gnt, RR); tick();
    req[0] = 0; req[1] = 0;
    sample(); tick();
    sample(); tick();

    // idle single read
    set_m(0, 1, 0, 32'h10, '0);
    stall_cnt = 0;
    sample(); chk("rd_stall", bus.cpu_stall, 1); chk("rd_nogntyet", bus.m0_gnt, 0); tick();
    sample(); chk("rd_gnt", bus.m0_gnt, 1); chk("rd_memread", bus.mem_read, 1);
    chk("rd_addr", bus.mem_addr, 32'h10); tick();
    req[0] = 0;
    sample(); chk("rd_rvalid", bus.m0_rvalid, 1); chk("rd_rdata", bus.m0_rdata, 32'hDEADBEEF); tick();
    sample(); chk("rd_rvalid_pulse", bus.m0_rvalid, 0); chk("rd_rdata_hold", bus.m0_rdata, 32'hDEADBEEF);
    chk("rd_stall_cycles", stall_cnt, 1); tick();

    // forced release after MAX_BURST beats
    set_m(1, 1, 1, 32'h300, 32'h1111);
    sample(); tick();
    sample(); chk("fr_b1_gnt1", bus.m1_gnt, 1); chk("fr_b1_write", bus.mem_write, 1); tick();
    set_m(1, 1, 1, 32'h304, 32'h2222);
    set_m(0, 1, 0, 32'h40, '0);
    stall_cnt = 0;
    sample(); tick();
    set_m(1, 1, 1, 32'h308, 32'h3333);
    sample(); tick();
    set_m(1, 1, 1, 32'h30C, 32'h4444);
    sample(); chk("fr_b4_gnt1", bus.m1_gnt, 1); chk("fr_b4_wdata", bus.mem_wdata, 32'h4444); tick();
    set_m(1, 1, 1, 32'h310, 32'h5555);
    sample(); chk("fr_gnt0", bus.m0_gnt, 1); chk("fr_gnt1_off", bus.m1_gnt, 0);
    chk("fr_stall_cycles", stall_cnt, 3); tick();
    req[0] = 0;
    sample(); tick();
    sample(); chk("fr_back_gnt1", bus.m1_gnt, 1); tick();
    req[1] = 0;
    sample(); tick();

    // uncontended stream of 10 reads
    set_m(0, 1, 0, 32'h1000, '0);
    sample(); tick();
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("un_gnt", bus.m0_gnt, 1);
      chk("un_read", bus.mem_read, 1);
      chk("un_cnt", dut.cnt_q, (i > 4) ? 4 : i);
      tick();
      addr[0] = 32'h1000 + 32'(4 * (i + 1));
    end
    req[0] = 0;
    sample(); chk("un_cnt_sat", dut.cnt_q, 4); chk("un_gnt_hold", bus.m0_gnt, 1); tick();

    // hand-off on voluntary release
    set_m(0, 1, 0, 32'h2000, '0);
    sample(); tick();
    sample(); tick();
    set_m(1, 1, 0, 32'h3000, '0);
    sample(); tick();
    req[0] = 0;
    sample(); tick();
    sample(); chk("ho_gnt1", bus.m1_gnt, 1); chk("ho_cnt", dut.cnt_q, 0); tick();

    // reset during m1's second read beat
    addr[1] = 32'h3004;
    reset = 1'b1;
    sample(); chk("rm_b2_gnt1", bus.m1_gnt, 1); tick();
    reset = 1'b0;
    req[1] = 0;
    sample();
    chk("rm_gnt0", bus.m0_gnt, 0);
    chk("rm_gnt1", bus.m1_gnt, 0);
    chk("rm_rv1", bus.m1_rvalid, 0);
    chk("rm_read", bus.mem_read, 0);
    chk("rm_state", dut.state_q, IDLE);
    tick();

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      sample();
      tick();
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (pb == i) begin
            if ($urandom_range(0, 3) == 0) req[i] = 0;
            else set_m(i, 1, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? 32'h10 : $urandom, $urandom);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          set_m(i, 1, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 32'h10 : $urandom, $urandom);
        end
      end
      reset = ($urandom_range(0, 149) == 0);
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width in bits.
REQ-002 Parameter: DATA_W, 32, data width in bits.
REQ-003 Parameter: MAX_BURST, 4, maximum consecutive granted beats while the other master waits; legal range 1..16.
REQ-004 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Ports: m0_req, m0_we  input  1 each  CPU MEM-stage request and write-enable.
REQ-007 Ports: m0_addr  input  ADDR_W; m0_wdata  input  DATA_W.
REQ-008 Ports: m0_gnt, m0_rvalid  output  1 each; m0_rdata  output  DATA_W.
REQ-009 Ports: m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata; external-device master, same widths and meanings as m0.
REQ-010 Port: cpu_stall  output  1  high when m0_req is high and m0_gnt is low.
REQ-011 Ports: mem_read, mem_write  output  1 each; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; these drive the shared data memory.
REQ-012 Port: mem_rdata  input  DATA_W  combinational read data from memory.

Function
REQ-013 State machine: the states SHALL be IDLE, OWN0 and OWN1; mN_gnt SHALL be high exactly in state OWNN, decoded from registered state.
REQ-014 IDLE SHALL move to OWNx one cycle after req is seen; grant latency from an idle bus SHALL be 1 cycle.
REQ-015 A beat SHALL occur in every cycle with mN_gnt=1 and mN_req=1.
  - Read beat: mem_read=1.
  - Write beat: mem_write=1.
  - mem_addr and mem_wdata SHALL be muxed from the owner.
REQ-016 With no beat, mem_read and mem_write SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-017 On a read beat, mN_rdata SHALL register mem_rdata and mN_rvalid SHALL pulse high for exactly one cycle, in the following cycle; mN_rdata SHALL hold its value otherwise.
REQ-018 Beat counter: it SHALL count granted beats of the current owner (4 bits) and SHALL reset to 0 on every ownership change.
REQ-019 Release by dropping req: when the owner drops req, state SHALL go to the other OWN state next cycle if that master's req is high, else to IDLE.
REQ-020 Forced release: when the owner completes beat MAX_BURST while the other req is high, ownership SHALL switch next cycle with no idle gap.
REQ-021 With the other req low, the owner SHALL keep the grant indefinitely and the counter SHALL saturate at MAX_BURST.
REQ-022 Simultaneous requests in IDLE SHALL be resolved per REQ-027/028.
REQ-023 Requester rules:
  - A master SHALL hold req, we, addr and wdata stable until granted.
  - The arbiter SHALL NOT check this rule.

Reset
REQ-024 Reset SHALL force:
  - state to IDLE and all gnt to 0;
  - rvalid to 0, rdata to 0 and the counter to 0;
  - the last-grant pointer to m1.
REQ-025 Reset mid-burst SHALL abort the burst; a read beat in the reset cycle SHALL NOT produce rvalid.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-027 With ARB_ROUND_ROBIN_EN defined: on a tie the master not granted last SHALL win, and the last-grant pointer SHALL update on every entry to an OWN state.
REQ-028 Without ARB_ROUND_ROBIN_EN: m0 SHALL always win ties and the pointer SHALL be absent; the forced release of REQ-020 SHALL still apply.

Structure
REQ-029 Shared package: the state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the default width constants SHALL live in the shared CPU package.
REQ-030 Sub-module: one sub-module, arb_owner_mux, SHALL implement the combinational master-to-memory mux; the FSM, counter and read-return registers SHALL be in mem_arbiter.

Verification
REQ-031 Idle single read: reset, then m0 read at addr 0x10 with mem_rdata=0xDEADBEEF -> m0_gnt at cycle+1, m0_rvalid at cycle+2 with m0_rdata=0xDEADBEEF, cpu_stall high for 1 cycle.
REQ-032 Tie: m0 and m1 request in the same IDLE cycle -> without macro m0 is granted; with macro m0 is granted first after reset, then m1 on the next tie.
REQ-033 Forced release: m1 streams writes and m0 requests during m1's beat 2 (MAX_BURST=4) -> m1 gets 4 beats, m0_gnt the next cycle, no idle cycle, cpu_stall high for 3 cycles.
REQ-034 Uncontended: m0 streams 10 reads with m1 idle -> 10 consecutive beats, counter saturates at 4, grant never drops.
REQ-035 Reset mid-burst: assert reset during m1's beat 2 of a read -> next cycle all gnt=0 and rvalid=0, mem_read=0, state IDLE.
REQ-036 Hand-off: m0 drops req while m1_req is held -> m1_gnt the following cycle, counter 0.
